// File: rtl/adc_sample_rx.sv
// I2S ADC receiver: oversamples sclk/lrclk/sdata in the clock domain and buffers sign-extended samples in a FIFO.
// Define ADC_RX_STEREO_EN to capture right-channel frames as well; by default only left samples are kept.
module adc_sample_rx #(
   parameter int DWIDTH      = 32,
   parameter int SAMPLE_BITS = 20,
   parameter int FIFO_DEPTH  = 4,
   parameter int CNT_W       = $clog2(FIFO_DEPTH) + 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              adc_sclk,
   input  logic              adc_lrclk,
   input  logic              adc_sdata,
   input  logic              rd_en,
   input  logic              ovf_clr,
   output logic [DWIDTH-1:0] adcdata,
   output logic              sample_valid,
   output logic              sample_chan,
   output logic [CNT_W-1:0]  fifo_count,
   output logic              overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = $clog2(SAMPLE_BITS + 1);

   typedef enum logic [2:0] {S_IDLE, S_SKIP, S_SHIFT, S_PUSH, S_WAIT} state_t;

   state_t                 state;
   logic                   sclk_s1, sclk_s2, sclk_s3;
   logic                   lrclk_s1, lrclk_s2, lrclk_s3;
   logic                   sdata_s1, sdata_s2;
   logic                   sclk_rise, lr_edge, lr_start;
   logic [BW-1:0]          bit_cnt;
   logic [SAMPLE_BITS-1:0] shift;
   logic                   wr_req;
   logic [DWIDTH-1:0]      wr_data;

   logic [DWIDTH-1:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]          wptr, rptr;
   logic [CNT_W-1:0]       count;
   logic                   empty, full, pop, push_ok, drop;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sclk_s1  <= 1'b0;
         sclk_s2  <= 1'b0;
         sclk_s3  <= 1'b0;
         lrclk_s1 <= 1'b0;
         lrclk_s2 <= 1'b0;
         lrclk_s3 <= 1'b0;
         sdata_s1 <= 1'b0;
         sdata_s2 <= 1'b0;
      end else begin
         sclk_s1  <= adc_sclk;
         sclk_s2  <= sclk_s1;
         sclk_s3  <= sclk_s2;
         lrclk_s1 <= adc_lrclk;
         lrclk_s2 <= lrclk_s1;
         lrclk_s3 <= lrclk_s2;
         sdata_s1 <= adc_sdata;
         sdata_s2 <= sdata_s1;
      end
   end

   assign sclk_rise = sclk_s2 & ~sclk_s3;
   assign lr_edge   = lrclk_s2 ^ lrclk_s3;

   // Which lrclk edges open a frame: both in stereo mode, only the falling (left) edge otherwise.
`ifdef ADC_RX_STEREO_EN
   assign lr_start = lr_edge;
`else
   assign lr_start = lrclk_s3 & ~lrclk_s2;
`endif

   // Frame FSM; any lrclk edge outside PUSH restarts framing, discarding a partial sample.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= S_IDLE;
         bit_cnt <= '0;
         shift   <= '0;
         wr_req  <= 1'b0;
      end else begin
         wr_req <= 1'b0;
         case (state)
            S_IDLE, S_WAIT: begin
               if (lr_edge) state <= lr_start ? S_SKIP : S_WAIT;
            end
            S_SKIP: begin
               if (lr_edge) begin
                  state <= lr_start ? S_SKIP : S_WAIT;
               end else if (sclk_rise) begin
                  state   <= S_SHIFT;
                  bit_cnt <= '0;
               end
            end
            S_SHIFT: begin
               if (lr_edge) begin
                  state <= lr_start ? S_SKIP : S_WAIT;
               end else if (sclk_rise) begin
                  shift   <= {shift[SAMPLE_BITS-2:0], sdata_s2};
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == BW'(SAMPLE_BITS - 1)) begin
                     state  <= S_PUSH;
                     wr_req <= 1'b1;
                  end
               end
            end
            S_PUSH:  state <= S_WAIT;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign wr_data = {{(DWIDTH-SAMPLE_BITS){shift[SAMPLE_BITS-1]}}, shift};

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(FIFO_DEPTH));
   assign pop     = rd_en & ~empty;
   assign push_ok = wr_req & (~full | pop);
   assign drop    = wr_req & full & ~pop;

   // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
   always_ff @(posedge clock) begin
      if (push_ok) mem[wptr] <= wr_data;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) wptr <= wptr + 1'b1;
         if (pop)     rptr <= rptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (drop)         overflow <= 1'b1;
         else if (ovf_clr) overflow <= 1'b0;
      end
   end

   always_comb begin
      adcdata = '0;
      if (!empty) adcdata = mem[rptr];
   end

   assign sample_valid = ~empty;
   assign fifo_count   = count;

`ifdef ADC_RX_STEREO_EN
   logic cur_chan;
   logic chan_mem [FIFO_DEPTH];

   // Channel tag follows the lrclk level of the edge that opened the frame; PUSH ignores edges.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                          cur_chan <= 1'b0;
      else if (lr_edge && state != S_PUSH) cur_chan <= lrclk_s2;
   end

   always_ff @(posedge clock) begin
      if (push_ok) chan_mem[wptr] <= cur_chan;
   end

   always_comb begin
      sample_chan = 1'b0;
      if (!empty) sample_chan = chan_mem[rptr];
   end
`else
   assign sample_chan = 1'b0;
`endif

endmodule

// File: tb/tb_adc_sample_rx.sv
// Directed bench for adc_sample_rx: drives I2S frames at 8x oversampling and checks hand-computed samples.
module tb_adc_sample_rx;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        adc_sclk = 1'b0;
   logic        adc_lrclk = 1'b0;
   logic        adc_sdata = 1'b0;
   logic        rd_en = 1'b0;
   logic        ovf_clr = 1'b0;
   logic [31:0] adcdata;
   logic        sample_valid;
   logic        sample_chan;
   logic [2:0]  fifo_count;
   logic        overflow;

   int errorCount = 0;
   int checkCount = 0;

   adc_sample_rx dut (
      .clock(clock),
      .reset(reset),
      .adc_sclk(adc_sclk),
      .adc_lrclk(adc_lrclk),
      .adc_sdata(adc_sdata),
      .rd_en(rd_en),
      .ovf_clr(ovf_clr),
      .adcdata(adcdata),
      .sample_valid(sample_valid),
      .sample_chan(sample_chan),
      .fifo_count(fifo_count),
      .overflow(overflow)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   task automatic sclkPulse();
      #40 adc_sclk = 1'b1;
      #40 adc_sclk = 1'b0;
   endtask

   // One 25-bit slot: delay bit, 20 data bits MSB first, 4 trailing bits.
   // mode 1 checks push latency around the LSB; mode 2 pops during the PUSH cycle.
   task automatic applyStimulus(input logic ch, input logic [19:0] data, input logic trail, input int mode);
      #1;
      @(negedge clock);
      adc_lrclk = ch;
      adc_sdata = 1'b0;
      sclkPulse();
      for (int i = 19; i >= 0; i--) begin
         adc_sdata = data[i];
         if (i == 0 && mode != 0) begin
            #40 adc_sclk = 1'b1;
            repeat (3) @(posedge clock);
            #1;
            if (mode == 1) checkOutput("latency_not_early", 32'(sample_valid), 32'd0);
            if (mode == 2) rd_en = 1'b1;
            @(posedge clock);
            #1;
            if (mode == 1) begin
               checkOutput("latency_valid", 32'(sample_valid), 32'd1);
               checkOutput("latency_data", adcdata, 32'h0007FFFF);
               checkOutput("latency_count", 32'(fifo_count), 32'd1);
            end
            if (mode == 2) begin
               rd_en = 1'b0;
               checkOutput("pushpop_count", 32'(fifo_count), 32'd4);
               checkOutput("pushpop_ovf", 32'(overflow), 32'd0);
            end
            #4 adc_sclk = 1'b0;
         end else begin
            sclkPulse();
         end
      end
      adc_sdata = trail;
      repeat (4) sclkPulse();
   endtask

   task automatic leftFrame(input logic [19:0] data, input logic trail, input int mode);
      adc_lrclk = 1'b1;
      repeat (3) sclkPulse();
      applyStimulus(1'b0, data, trail, mode);
   endtask

   task automatic partialLeft(input logic [19:0] data, input int nbits);
      adc_lrclk = 1'b1;
      repeat (3) sclkPulse();
      #1;
      @(negedge clock);
      adc_lrclk = 1'b0;
      adc_sdata = 1'b0;
      sclkPulse();
      for (int i = 19; i > 19 - nbits; i--) begin
         adc_sdata = data[i];
         sclkPulse();
      end
   endtask

   task automatic popSample(input string tag, input logic [31:0] expected);
      #1;
      @(negedge clock);
      checkOutput(tag, adcdata, expected);
      rd_en = 1'b1;
      @(posedge clock);
      #1 rd_en = 1'b0;
   endtask

   initial begin
      $display("[TB] adc_sample_rx directed test start");
      #23;
      checkOutput("rst_data", adcdata, 32'd0);
      checkOutput("rst_valid", 32'(sample_valid), 32'd0);
      checkOutput("rst_count", 32'(fifo_count), 32'd0);
      checkOutput("rst_ovf", 32'(overflow), 32'd0);
      checkOutput("rst_chan", 32'(sample_chan), 32'd0);
      #3 reset = 1'b1;

      // Positive full scale, latency, then pop to empty.
      leftFrame(20'h7FFFF, 1'b0, 1);
      checkOutput("t1_chan", 32'(sample_chan), 32'd0);
      popSample("t1_head", 32'h0007FFFF);
      checkOutput("t1_empty_data", adcdata, 32'd0);
      checkOutput("t1_empty_valid", 32'(sample_valid), 32'd0);
      rd_en = 1'b1;
      @(posedge clock);
      #1 rd_en = 1'b0;
      checkOutput("t1_pop_empty_count", 32'(fifo_count), 32'd0);

      // Sign extension and trailing slot bits.
      leftFrame(20'h80000, 1'b0, 0);
      popSample("t2_negative", 32'hFFF80000);
      leftFrame(20'h00001, 1'b1, 0);
      popSample("t2_trail_ones", 32'h00000001);

      // Overflow: fifth sample dropped, sticky until cleared.
      for (int k = 1; k <= 5; k++) leftFrame(20'(k), 1'b0, 0);
      checkOutput("t3_count_full", 32'(fifo_count), 32'd4);
      checkOutput("t3_ovf_set", 32'(overflow), 32'd1);
      for (int k = 1; k <= 4; k++) popSample($sformatf("t3_pop%0d", k), 32'(k));
      checkOutput("t3_count_drained", 32'(fifo_count), 32'd0);
      checkOutput("t3_ovf_sticky", 32'(overflow), 32'd1);
      ovf_clr = 1'b1;
      @(posedge clock);
      #1 ovf_clr = 1'b0;
      checkOutput("t3_ovf_clr", 32'(overflow), 32'd0);

      // Push and pop together while full.
      for (int k = 'h11; k <= 'h14; k++) leftFrame(20'(k), 1'b0, 0);
      checkOutput("t4_count_full", 32'(fifo_count), 32'd4);
      leftFrame(20'h00015, 1'b0, 2);
      for (int k = 'h12; k <= 'h15; k++) popSample($sformatf("t4_pop%0h", k), 32'(k));
      checkOutput("t4_ovf_clear", 32'(overflow), 32'd0);

      // Frame aborted after 10 bits, then a clean frame.
      partialLeft(20'h5A5A5, 10);
      adc_lrclk = 1'b1;
      repeat (3) sclkPulse();
      checkOutput("t5_abort_count", 32'(fifo_count), 32'd0);
      leftFrame(20'h12345, 1'b0, 0);
      checkOutput("t5_count", 32'(fifo_count), 32'd1);
      checkOutput("t5_data", adcdata, 32'h00012345);

      // Asynchronous reset mid-frame.
      partialLeft(20'h33333, 8);
      #3 reset = 1'b0;
      #1;
      checkOutput("t6_rst_data", adcdata, 32'd0);
      checkOutput("t6_rst_valid", 32'(sample_valid), 32'd0);
      checkOutput("t6_rst_count", 32'(fifo_count), 32'd0);
      checkOutput("t6_rst_ovf", 32'(overflow), 32'd0);
      #12 reset = 1'b1;
      leftFrame(20'h0ABCD, 1'b0, 0);
      checkOutput("t6_chan_left", 32'(sample_chan), 32'd0);
      popSample("t6_after_rst", 32'h0000ABCD);
      applyStimulus(1'b1, 20'h00002, 1'b0, 0);
`ifdef ADC_RX_STEREO_EN
      checkOutput("t6_right_count", 32'(fifo_count), 32'd1);
      checkOutput("t6_right_chan", 32'(sample_chan), 32'd1);
      checkOutput("t6_right_data", adcdata, 32'h00000002);
`else
      checkOutput("t6_right_count", 32'(fifo_count), 32'd0);
      checkOutput("t6_right_valid", 32'(sample_valid), 32'd0);
      checkOutput("t6_right_chan", 32'(sample_chan), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule

// File: doc/adc_sample_rx.md
Name: adc_sample_rx

Overview:
Serial audio ADC front end that sits directly upstream of the CPU's adcdata input. It oversamples an I2S-format ADC stream (bit clock, word select, data) in the CPU clock domain and deserialises SAMPLE_BITS-bit two's-complement samples. Each sample is sign-extended to DWIDTH and buffered in a small FIFO. The CPU pops the FIFO head with rd_en when it executes the ADC-read instruction.

Parameters:
DWIDTH, 32, width of adcdata, matching the CPU data width
SAMPLE_BITS, 20, significant bits per sample, MSB first; later slot bits are ignored
FIFO_DEPTH, 4, number of buffered samples; must be a power of two, 2 or more
CNT_W, $clog2(FIFO_DEPTH)+1, width of fifo_count

Ports:
clock  in  1  system clock; all state on its rising edge
reset  in  1  asynchronous, active-low reset
adc_sclk  in  1  I2S bit clock, asynchronous to clock
adc_lrclk  in  1  I2S word select; 0 = left, 1 = right; asynchronous
adc_sdata  in  1  I2S serial data; asynchronous
rd_en  in  1  pop request, one cycle per sample consumed
ovf_clr  in  1  clears the sticky overflow flag
adcdata  out  DWIDTH  FIFO head, sign-extended; 0 when empty
sample_valid  out  1  FIFO not empty
sample_chan  out  1  channel of the head sample; 1 = right
fifo_count  out  CNT_W  number of samples held, 0..FIFO_DEPTH
overflow  out  1  sticky flag: a sample was dropped

Behaviour:
- Reset (reset = 0):
  - All outputs are 0.
  - Synchronisers clear to 0, the FSM enters IDLE and FIFO pointers clear.
  - A partial frame in progress is discarded.
- Input synchronisation:
  - adc_sclk, adc_lrclk and adc_sdata each pass through a 2-flop synchroniser.
  - A third register on sclk and lrclk provides edge detection.
  - sclk rise = synchronised sclk is 1 and was 0 in the previous cycle.
  - The clock frequency must be at least 4x the adc_sclk frequency. The bench enforces this; the RTL does not check it.
- FSM states and transitions:
  - IDLE: wait for an lrclk edge. A falling edge selects left; a rising edge selects right, and is honoured only with the optional feature. Go to SKIP.
  - SKIP: wait for the first sclk rise, which is the I2S one-bit delay. Go to SHIFT and clear the bit counter.
  - SHIFT: on each sclk rise, shift in adc_sdata (MSB first) and increment the counter. When the counter reaches SAMPLE_BITS, go to PUSH.
  - PUSH: one cycle. Issue a FIFO write of {sign-extend(shift[SAMPLE_BITS-1:0])} with its channel tag, then go to WAIT.
  - WAIT: ignore sclk. On the next lrclk edge, behave as IDLE does.
  - Any state: an lrclk edge during SKIP or SHIFT aborts the frame with no push, and the new edge restarts the frame in SKIP.
- Latency: adcdata and sample_valid update 2 clocks after the cycle in which the LSB sclk rise is detected, i.e. PUSH cycle + 1.
- FIFO:
  - Registered storage; adcdata is driven combinationally from the head entry.
  - Pop: rd_en = 1 and count > 0 advances the read pointer at the clock edge. rd_en while empty is ignored.
  - Push while count < FIFO_DEPTH stores the sample.
  - Push while full with no pop in the same cycle drops the new sample, sets overflow and leaves the FIFO unchanged.
  - Push and pop in the same cycle are both accepted, including when full, and count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- overflow:
  - Stays set until an ovf_clr cycle.
  - If an overflow event and ovf_clr occur in the same cycle, the set wins.

Optional Feature:
ADC_RX_STEREO_EN
- Defined: right-channel frames (lrclk rising edge) are captured as well. Samples are pushed in arrival order, and sample_chan reports the head sample's channel tag.
- Undefined: right-channel frames are ignored (lrclk rising edge leads to WAIT-equivalent idling). Only left samples are pushed and sample_chan is tied to 0.

Test Plan:
1. Left frame with sample 0x7FFFF -> adcdata = 0x0007FFFF, sample_valid = 1 and fifo_count = 1 at LSB-detect + 2 clocks; rd_en pulse -> adcdata = 0, sample_valid = 0.
2. Left frame with sample 0x80000 -> adcdata = 0xFFF80000. Frame with sample 0x00001 -> 0x00000001, and trailing slot bits set to 1 do not alter it.
3. Five left frames 0x00001..0x00005, no reads -> fifo_count = 4, overflow = 1. Four pops return 1, 2, 3, 4. ovf_clr -> overflow = 0.
4. FIFO full, rd_en asserted in the PUSH cycle of a new frame -> fifo_count stays 4, overflow stays 0, new sample last in order.
5. lrclk toggles after 10 data bits -> no push, fifo_count unchanged. The following complete frame 0x12345 is captured correctly.
6. reset pulsed low mid-SHIFT -> all outputs 0 asynchronously; next full frame 0x0ABCD -> adcdata = 0x0000ABCD. With ADC_RX_STEREO_EN, a right frame 0x00002 -> sample_chan = 1; without it, no push occurs.
